// File: rtl/psum_pkg.sv
// Shared definitions for the psum feeder: default geometry, the feeder FSM
// state encoding and the lane-index width helper.
package psum_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

  // Width of an index that selects one of n lanes; never narrower than 1 bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = lane_w(COL);

endpackage

// File: rtl/psum_row_fifo.sv
// Row-wide synchronous FIFO with a combinational head read; pointers wrap
// modulo depth (power of two) and count is kept separately so full != empty.
module psum_row_fifo #(
  parameter int width = 128,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(depth);
  localparam int CNT_W = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/psum_feeder.sv
// Buffers psum rows and replays each one as a contiguous col-word burst to the
// sfu, holding off the next burst until the sfu signals completion.
module psum_feeder
  import psum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [col*psum_bw-1:0]      in_data,
  output logic                        out_valid,
  output logic [psum_bw-1:0]          out_data,
  input  logic                        sfu_done,
  output logic                        busy,
  output logic [$clog2(depth):0]      fifo_count
);

  localparam int ROW_W = col * psum_bw;
  localparam int IDX_W = lane_w(col);

  feeder_state_t      state;
  logic [IDX_W-1:0]   idx;
  logic [ROW_W-1:0]   head_row;
  logic [psum_bw-1:0] lane_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  // idx wraps to 0 as the last lane is registered, so idx==0 in STREAM marks the closing edge.
  assign pop      = (state == STREAM) && (idx == '0);
  assign busy     = (state != IDLE) || ~fifo_empty;

  psum_row_fifo #(
    .width (ROW_W),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head_row),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < col; i++) begin
      if (idx == IDX_W'(i)) lane_data = head_row[i*psum_bw +: psum_bw];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            out_data  <= head_row[psum_bw-1:0];
            idx       <= IDX_W'(1);
          end
        end
        STREAM: begin
          if (idx == '0) begin
            state     <= WAIT_DONE;
            out_valid <= 1'b0;
            out_data  <= '0;
          end else begin
            out_data <= lane_data;
            idx      <= (idx == IDX_W'(col - 1)) ? '0 : idx + IDX_W'(1);
          end
        end
        WAIT_DONE: begin
          out_valid <= 1'b0;
          if (sfu_done) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/psum_feeder.md
Name: psum_feeder

Overview:
- Sits directly upstream of the sfu.
- Accepts one row of column psums per handshake from the MAC array / ofifo and buffers rows in a small FIFO.
- Serialises each row into one contiguous valid burst of `col` words on the sfu input.
- Holds valid low between bursts until the sfu reports completion (its valid_out), so each sfu accumulate/ReLU covers exactly one row.

Parameters:
- psum_bw, 16, width of one psum word (two's complement).
- col, 8, psums per row, which is also the burst length.
- depth, 4, FIFO depth in rows; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; one clock, all state sampled on rising clk edge
- in_valid  in  1  upstream row valid
- in_ready  out  1  FIFO can accept a row
- in_data  in  col*psum_bw  row; lane i at bits [i*psum_bw +: psum_bw], lane 0 in the LSBs
- out_valid  out  1  drives sfu valid_in
- out_data  out  psum_bw  drives sfu psum_in
- sfu_done  in  1  sfu valid_out; marks the current burst as consumed
- busy  out  1  high when state ≠ IDLE or FIFO non-empty
- fifo_count  out  $clog2(depth)+1  rows currently buffered

Behaviour:
- Reset (synchronous): FIFO pointers and count → 0, state → IDLE, lane index → 0, out_valid → 0, out_data → 0. After reset: in_ready = 1, busy = 0, fifo_count = 0.
- Reset asserted mid-burst or mid-wait: buffered rows are discarded, and out_valid is 0 from the next edge.
- Push occurs when in_valid & in_ready at a rising edge.
  - in_ready = (fifo_count < depth), combinational from count only, with no pop-through when full.
  - in_valid while full: ignored, data not stored.
- Pop of the head row occurs at the edge that emits its last lane.
  - Simultaneous push and pop: count unchanged, and both succeed.
- FSM states: IDLE, STREAM, WAIT_DONE.
  - IDLE: if fifo_count > 0, go to STREAM at the next edge. At that edge register out_valid = 1 and out_data = lane 0 of the head row, and set lane index to 1.
  - STREAM: at each edge, register lane[idx] and increment idx. The edge after lane col-1 is presented does the following: out_valid ← 0, out_data ← 0, pop the head, go to WAIT_DONE.
  - WAIT_DONE: out_valid = 0. Stay until sfu_done = 1, then go to IDLE at that edge.
- Resulting sequence:
  - out_valid is high for exactly col consecutive cycles per row.
  - There is at least one idle cycle before WAIT_DONE exits, plus one more cycle in IDLE, so consecutive bursts are separated by ≥2 low cycles.
- Latency: row pushed at edge E0 into an empty, IDLE block → out_valid high after E1, lane k present during cycle E1+k, out_valid low after E1+col.
- sfu_done is ignored in IDLE and STREAM (no effect, no latching).
- out_data is a pure pass-through of lane bits; no arithmetic or sign changes in this block.
- fifo_count wraps never; pointers wrap modulo depth.

Decomposition:
- Shared package psum_pkg: PSUM_BW and COL defaults, the state enum (IDLE/STREAM/WAIT_DONE), and a lane-index width constant ($clog2(col)).
- One sub-module: psum_row_fifo, a synchronous FIFO of depth rows × col*psum_bw.
  - Ports: push, pop, wdata, rdata (head, combinational read), count, full, empty.
- The FSM and lane mux live in psum_feeder.

Test Plan:
1. col=5, sfu instance downstream.
   - Stimulus: push row lanes {1,2,3,4,5}.
   - Response: out_data 1,2,3,4,5 on 5 consecutive out_valid cycles starting 2 edges after the push, then out_valid low; sfu psum_out = 15 with valid_out; feeder returns to IDLE, busy = 0.
2. col=5.
   - Stimulus: push {-3,1,0,0,0}, with the sfu reset before the burst.
   - Response: lanes streamed in order, sfu psum_out = 0 (ReLU of -2); 0xFFFD appears on out_data in the first burst cycle.
3. depth=4, col=5, sfu_done held 0.
   - Stimulus: push 6 rows back-to-back.
   - Response: first 5 pushes accepted (head popped after its burst frees one slot); in_ready drops to 0 with fifo_count = 4; 6th row held until a pop; no second burst starts before sfu_done.
4. Stimulus: pulse sfu_done during STREAM, then stop pulsing.
   - Response: the pulse is ignored; the feeder remains in WAIT_DONE after the burst until a later sfu_done pulse; next burst begins 2 edges after that pulse.
5. Stimulus: assert reset for one cycle at lane 2 of a burst with 2 rows buffered.
   - Response: out_valid = 0 and fifo_count = 0 after the edge, in_ready = 1; a subsequent push streams normally from lane 0.
6. Stimulus: push and pop in the same cycle with fifo_count = 2.
   - Response: count stays 2, and row order is preserved on out_data.
